// File: rtl/instruction_fetch.sv
// instruction_fetch: issues word-aligned fetches to instruction memory, one
// request outstanding at a time, and queues the returned words in a small
// FIFO (BUF_DEPTH entries) for the core.
//
// Ports:
//   clock, reset_n              rising-edge clock, async active-low reset
//   imem_address/_read_enabled  fetch request (address stable until ack)
//   imem_ack/_data/_err_invalid_address  memory response for the request
//   redirect, redirect_target   branch/jump from the core: flush + new PC
//   instruction/_pc/_valid      buffer head, popped when instruction_ready=1
//   err_misaligned, err_fetch   sticky error flags, cleared only by reset
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] imem_address,
  output logic        imem_read_enabled,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        imem_err_invalid_address,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic        err_misaligned,
  output logic        err_fetch
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQUEST, HALT} state_e;
  state_e state_q, state_d;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        drop_q, drop_d;
  logic        err_mis_q, err_mis_d;
  logic        err_fetch_q, err_fetch_d;

  logic [BUF_DEPTH-1:0][31:0] buf_pc_q, buf_data_q;
  logic [PW-1:0]              rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]              count_q;

  logic redir_ok, redir_bad, ack_v, push, pop, fetch_fault, has_space, issue;

  assign redir_bad   = redirect && (redirect_target[1:0] != 2'b00);
  assign redir_ok    = redirect && !redir_bad;
  // acks outside REQUEST are not ours and are ignored
  assign ack_v       = (state_q == REQUEST) && imem_ack;
  // a redirect in the ack cycle wins: the returned word (or its error) is stale
  assign push        = ack_v && !drop_q && !redirect && !imem_err_invalid_address;
  assign fetch_fault = ack_v && !drop_q && !redirect && imem_err_invalid_address;
  // only issued from IDLE, so the outstanding request always has a free slot
  // reserved and a push can never overflow the buffer
  assign has_space   = count_q < CW'(BUF_DEPTH);
  assign issue       = (state_q == IDLE) && has_space && !redirect && !err_mis_q;
  assign pop         = instruction_valid && instruction_ready;

  assign imem_address = (state_q == REQUEST) ? req_addr_q : fetch_pc_q;

  always_comb begin
    state_d           = state_q;
    imem_read_enabled = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redir_bad || err_mis_q) begin
          state_d = HALT;
        end else if (issue) begin
          state_d           = REQUEST;
          // request leaves in the same cycle; suppressed while in reset
          imem_read_enabled = reset_n;
        end
      end
      REQUEST: begin
        imem_read_enabled = 1'b1;
        if (ack_v) state_d = (redir_bad || err_mis_q || fetch_fault) ? HALT : IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_addr_d  = issue ? fetch_pc_q : req_addr_q;
    fetch_pc_d  = fetch_pc_q;
    if (redir_ok)  fetch_pc_d = redirect_target;
    else if (push) fetch_pc_d = req_addr_q + 32'd4;
    // a redirect with a request in flight poisons the next ack
    drop_d      = drop_q;
    if (ack_v)                                drop_d = 1'b0;
    else if (state_q == REQUEST && redirect)  drop_d = 1'b1;
    err_mis_d   = err_mis_q | redir_bad;
    err_fetch_d = err_fetch_q | fetch_fault;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= RESET_PC;
      drop_q      <= 1'b0;
      err_mis_q   <= 1'b0;
      err_fetch_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      drop_q      <= drop_d;
      err_mis_q   <= err_mis_d;
      err_fetch_q <= err_fetch_d;
    end
  end

  // instruction buffer; a redirect flush overrides any push/pop this cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_pc_q   <= '0;
      buf_data_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else if (redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        buf_pc_q[wr_ptr_q]   <= req_addr_q;
        buf_data_q[wr_ptr_q] <= imem_data;
        wr_ptr_q             <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign instruction_valid = (count_q != '0);
  assign instruction       = instruction_valid ? buf_data_q[rd_ptr_q] : 32'h0;
  assign instruction_pc    = instruction_valid ? buf_pc_q[rd_ptr_q]   : 32'h0;
  assign err_misaligned    = err_mis_q;
  assign err_fetch         = err_fetch_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a cycle table for streaming/backpressure,
// hand sequences for redirect/error corners, and a second instance with a
// RESET_PC near the top of the address space for PC wrap-around.
module tb_instruction_fetch;
  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic        clock, reset_n;
  logic [31:0] imem_address, imem_data, redirect_target;
  logic [31:0] instruction, instruction_pc;
  logic        imem_read_enabled, imem_ack, imem_err_invalid_address;
  logic        redirect, instruction_valid, instruction_ready;
  logic        err_misaligned, err_fetch;

  int   checks = 0;
  int   errors = 0;
  int   mem_lat = 1;
  logic mem_err = 1'b0;
  logic ready   = 1'b1;
  int   age_q;

  instruction_fetch u_dut (
    .clock(clock), .reset_n(reset_n),
    .imem_address(imem_address), .imem_read_enabled(imem_read_enabled),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .imem_err_invalid_address(imem_err_invalid_address),
    .redirect(redirect), .redirect_target(redirect_target),
    .instruction(instruction), .instruction_pc(instruction_pc),
    .instruction_valid(instruction_valid), .instruction_ready(instruction_ready),
    .err_misaligned(err_misaligned), .err_fetch(err_fetch)
  );

  // memory model: ack once a request has been outstanding mem_lat cycles
  always @(posedge clock or negedge reset_n)
    if (!reset_n)                              age_q <= 0;
    else if (imem_read_enabled && !imem_ack)   age_q <= age_q + 1;
    else                                       age_q <= 0;
  assign imem_ack                 = imem_read_enabled && (age_q >= mem_lat);
  assign imem_data                = imem_address ^ KEY;
  assign imem_err_invalid_address = mem_err;
  assign instruction_ready        = ready;

  // wrap-around instance, free running with ready=1 and 1-cycle memory
  logic [31:0] w_addr, w_data, w_instr, w_pc;
  logic        w_re, w_ack, w_valid, w_em, w_ef;
  logic        w_redir = 1'b0, w_err = 1'b0, w_ready = 1'b1;
  logic [31:0] w_tgt = 32'h0;
  int          w_age;
  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_wrap (
    .clock(clock), .reset_n(reset_n),
    .imem_address(w_addr), .imem_read_enabled(w_re),
    .imem_ack(w_ack), .imem_data(w_data), .imem_err_invalid_address(w_err),
    .redirect(w_redir), .redirect_target(w_tgt),
    .instruction(w_instr), .instruction_pc(w_pc),
    .instruction_valid(w_valid), .instruction_ready(w_ready),
    .err_misaligned(w_em), .err_fetch(w_ef)
  );
  always @(posedge clock or negedge reset_n)
    if (!reset_n)            w_age <= 0;
    else if (w_re && !w_ack) w_age <= w_age + 1;
    else                     w_age <= 0;
  assign w_ack  = w_re && (w_age >= 1);
  assign w_data = w_addr ^ KEY;

  logic [31:0] cap_pc[3], cap_in[3];
  int          cap_n = 0;
  always @(posedge clock)
    if (reset_n && w_valid && cap_n < 3) begin
      cap_pc[cap_n] <= w_pc;
      cap_in[cap_n] <= w_instr;
      cap_n         <= cap_n + 1;
    end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rdy;
    logic        re;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;
  vec_t vt[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic nx();
    @(posedge clock);
    #1;
  endtask

  // assert reset mid-cycle, check held values, release one edge later
  task automatic do_reset();
    reset_n = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    ready = 1'b1; mem_err = 1'b0; mem_lat = 1;
    #1;
    chk("rst_re",    imem_read_enabled, 1'b0);
    chk("rst_addr",  imem_address, 32'h0);
    chk("rst_valid", instruction_valid, 1'b0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_pc",    instruction_pc, 32'h0);
    chk("rst_emis",  err_misaligned, 1'b0);
    chk("rst_efet",  err_fetch, 1'b0);
    nx();
    reset_n = 1'b1;
  endtask

  logic [31:0] wexp[3];

  initial begin
    //          rdy   re    addr          vld   pc
    // streaming, 1-cycle memory, ready=1
    vt[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vt[1]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vt[2]  = '{1'b1, 1'b1, 32'h04, 1'b1, 32'h00};
    vt[3]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vt[4]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    vt[5]  = '{1'b1, 1'b1, 32'h08, 1'b0, 32'h00};
    vt[6]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h08};
    vt[7]  = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
    vt[8]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
    // after mid-request reset: ready=0 for 10 cycles, then drain
    vt[9]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    vt[10] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    vt[11] = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
    vt[12] = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
    for (int i = 13; i < 19; i++) vt[i] = '{1'b0, 1'b0, 32'h08, 1'b1, 32'h00};
    vt[19] = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
    vt[20] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    vt[21] = '{1'b1, 1'b1, 32'h08, 1'b0, 32'h00};
    vt[22] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h08};
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;

    redirect = 1'b0; redirect_target = 32'h0;
    reset_n = 1'b1;
    #1;
    do_reset();

    for (int i = 0; i < 23; i++) begin
      if (i == 9) begin
        // request to 0x10 is in flight; reset must abandon it
        #1;
        chk("prerst_re",   imem_read_enabled, 1'b1);
        chk("prerst_addr", imem_address, 32'h10);
        do_reset();
      end
      ready = vt[i].rdy;
      #1;
      chk($sformatf("v%0d_re", i),    imem_read_enabled, vt[i].re);
      chk($sformatf("v%0d_addr", i),  imem_address, vt[i].addr);
      chk($sformatf("v%0d_valid", i), instruction_valid, vt[i].vld);
      if (vt[i].vld) begin
        chk($sformatf("v%0d_pc", i),    instruction_pc, vt[i].pc);
        chk($sformatf("v%0d_instr", i), instruction, vt[i].pc ^ KEY);
      end
      nx();
    end

    // redirect while outstanding, ack 3 cycles later is dropped
    do_reset(); mem_lat = 4;
    #1; chk("rd_c0_re", imem_read_enabled, 1'b1); nx();
    redirect = 1'b1; redirect_target = 32'h100;
    #1; chk("rd_c1_addr", imem_address, 32'h0); nx();
    redirect = 1'b0;
    #1; chk("rd_c2_addr", imem_address, 32'h0); nx();
    #1; chk("rd_c3_re", imem_read_enabled, 1'b1); nx();
    #1; chk("rd_c4_valid", instruction_valid, 1'b0); nx();
    mem_lat = 1;
    #1;
    chk("rd_c5_valid", instruction_valid, 1'b0);
    chk("rd_c5_re",    imem_read_enabled, 1'b1);
    chk("rd_c5_addr",  imem_address, 32'h100);
    nx();
    #1; chk("rd_c6_valid", instruction_valid, 1'b0); nx();
    #1;
    chk("rd_c7_valid", instruction_valid, 1'b1);
    chk("rd_c7_pc",    instruction_pc, 32'h100);
    chk("rd_c7_instr", instruction, 32'h100 ^ KEY);

    // redirect coincident with ack and pop
    do_reset(); ready = 1'b0;
    nx(); nx();
    #1; chk("rap_c2_pc", instruction_pc, 32'h0); nx();
    ready = 1'b1; redirect = 1'b1; redirect_target = 32'h40;
    #1;
    chk("rap_c3_valid", instruction_valid, 1'b1);
    chk("rap_c3_addr",  imem_address, 32'h4);
    nx();
    redirect = 1'b0;
    #1;
    chk("rap_c4_valid", instruction_valid, 1'b0);
    chk("rap_c4_re",    imem_read_enabled, 1'b1);
    chk("rap_c4_addr",  imem_address, 32'h40);
    nx(); nx();
    #1;
    chk("rap_c6_valid", instruction_valid, 1'b1);
    chk("rap_c6_pc",    instruction_pc, 32'h40);

    // misaligned redirect -> sticky error and HALT
    do_reset();
    nx();
    redirect = 1'b1; redirect_target = 32'h102;
    #1; chk("mis_c1_re", imem_read_enabled, 1'b1); nx();
    redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("mis_h%0d_err", k),   err_misaligned, 1'b1);
      chk($sformatf("mis_h%0d_re", k),    imem_read_enabled, 1'b0);
      chk($sformatf("mis_h%0d_valid", k), instruction_valid, 1'b0);
      nx();
    end
    chk("mis_efet", err_fetch, 1'b0);

    // fetch error -> sticky error, HALT, buffered entry still poppable
    do_reset(); ready = 1'b0;
    nx(); nx();
    #1; chk("fe_c2_addr", imem_address, 32'h4); nx();
    mem_err = 1'b1;
    #1; chk("fe_c3_efet", err_fetch, 1'b0); nx();
    mem_err = 1'b0; ready = 1'b1;
    #1;
    chk("fe_c4_efet",  err_fetch, 1'b1);
    chk("fe_c4_re",    imem_read_enabled, 1'b0);
    chk("fe_c4_valid", instruction_valid, 1'b1);
    chk("fe_c4_pc",    instruction_pc, 32'h0);
    nx();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("fe_h%0d_valid", k), instruction_valid, 1'b0);
      chk($sformatf("fe_h%0d_re", k),    imem_read_enabled, 1'b0);
      chk($sformatf("fe_h%0d_efet", k),  err_fetch, 1'b1);
      nx();
    end
    do_reset();

    // PC wrap from the second instance
    chk("wrap_n", cap_n, 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wrap%0d_pc", k),    cap_pc[k], wexp[k]);
      chk($sformatf("wrap%0d_instr", k), cap_in[k], wexp[k] ^ KEY);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
